// File: rtl/pmd85_pkg.sv
// rtl/pmd85_pkg.sv - shared state encoding and PPI register addresses for the PMD85 core
package pmd85_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INIT   = 3'd1,
    ST_SETUP  = 3'd2,
    ST_STROBE = 3'd3,
    ST_HOLD   = 3'd4,
    ST_ACK    = 3'd5
  } ppi_state_t;

  localparam logic [1:0] PPI_PA = 2'd0;
  localparam logic [1:0] PPI_PB = 2'd1;
  localparam logic [1:0] PPI_PC = 2'd2;
  localparam logic [1:0] PPI_CW = 2'd3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ppi_rr_arbiter2.sv
// rtl/ppi_rr_arbiter2.sv - two-way round-robin grant; pointer moves past each taken grant
module ppi_rr_arbiter2 (
  input  logic       clk,
  input  logic       RESET,
  input  logic [1:0] req,
  input  logic       take,
  output logic       valid,
  output logic       id
);

  logic rr_ptr;

  always_comb begin
    valid = |req;
    id    = req[1];
    if (req[0] && req[1]) id = rr_ptr;
  end

  always_ff @(posedge clk) begin
    if (RESET) rr_ptr <= 1'b0;
    else if (take) rr_ptr <= ~id;
  end

endmodule

// File: rtl/ppi_bus_sequencer.sv
// rtl/ppi_bus_sequencer.sv - i8255 bus strobe sequencer shared by CPU decode and aux loader
module ppi_bus_sequencer
  import pmd85_pkg::*;
#(
  parameter int         SETUP_CYCLES  = 1,
  parameter int         STROBE_CYCLES = 2,
  parameter int         HOLD_CYCLES   = 1,
  parameter int         INIT_EN       = 1,
  parameter logic [7:0] INIT_CW       = 8'h8A
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       m0_req,
  input  logic       m0_wr,
  input  logic [1:0] m0_addr,
  input  logic [7:0] m0_wdata,
  output logic       m0_ack,
  output logic [7:0] m0_rdata,
  input  logic       m1_req,
  input  logic       m1_wr,
  input  logic [1:0] m1_addr,
  input  logic [7:0] m1_wdata,
  output logic       m1_ack,
  output logic [7:0] m1_rdata,
  output logic       ppi_cs_n,
  output logic       ppi_rd_n,
  output logic       ppi_wr_n,
  output logic [1:0] ppi_a,
  output logic [7:0] ppi_dout,
  input  logic [7:0] ppi_din,
  output logic       init_done,
  output logic       busy
);

  localparam int MAX_CYCLES = max3(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES);
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LD_SETUP  = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_STROBE = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_HOLD   = CNT_W'(HOLD_CYCLES - 1);

  ppi_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             take, gnt_valid, gnt_id;
  logic             txn_wr, txn_id, txn_init;
  logic             phase_end;

  ppi_rr_arbiter2 u_arb (
    .clk   (clk),
    .RESET (RESET),
    .req   ({m1_req, m0_req}),
    .take  (take),
    .valid (gnt_valid),
    .id    (gnt_id)
  );

  assign phase_end = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q <= (INIT_EN != 0) ? ST_INIT : ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    take    = 1'b0;
    case (state_q)
      ST_INIT: begin
        state_d = ST_SETUP;
        cnt_d   = LD_SETUP;
      end
      ST_IDLE: begin
        if (gnt_valid) begin
          take    = 1'b1;
          state_d = ST_SETUP;
          cnt_d   = LD_SETUP;
        end
      end
      ST_SETUP: begin
        if (phase_end) begin
          state_d = ST_STROBE;
          cnt_d   = LD_STROBE;
        end else cnt_d = cnt_q - CNT_W'(1);
      end
      ST_STROBE: begin
        if (phase_end) begin
          state_d = ST_HOLD;
          cnt_d   = LD_HOLD;
        end else cnt_d = cnt_q - CNT_W'(1);
      end
      ST_HOLD: begin
        if (phase_end) state_d = txn_init ? ST_IDLE : ST_ACK;
        else cnt_d = cnt_q - CNT_W'(1);
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so every pin changes on the same edge as the state.
  always_ff @(posedge clk) begin
    if (RESET) begin
      txn_wr    <= 1'b0;
      txn_id    <= 1'b0;
      txn_init  <= 1'b0;
      ppi_cs_n  <= 1'b1;
      ppi_rd_n  <= 1'b1;
      ppi_wr_n  <= 1'b1;
      ppi_a     <= '0;
      ppi_dout  <= '0;
      m0_ack    <= 1'b0;
      m1_ack    <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
      init_done <= (INIT_EN == 0);
      busy      <= 1'b0;
    end else begin
      if (state_q == ST_INIT) begin
        txn_wr   <= 1'b1;
        txn_init <= 1'b1;
        ppi_a    <= PPI_CW;
        ppi_dout <= INIT_CW;
      end else if (take) begin
        txn_wr   <= gnt_id ? m1_wr : m0_wr;
        txn_id   <= gnt_id;
        txn_init <= 1'b0;
        ppi_a    <= gnt_id ? m1_addr : m0_addr;
        ppi_dout <= gnt_id ? m1_wdata : m0_wdata;
      end
      ppi_cs_n <= !(state_d inside {ST_SETUP, ST_STROBE, ST_HOLD});
      ppi_wr_n <= !(state_d == ST_STROBE && txn_wr);
      ppi_rd_n <= !(state_d == ST_STROBE && !txn_wr);
      if (state_q == ST_STROBE && phase_end && !txn_wr && !txn_init) begin
        if (txn_id) m1_rdata <= ppi_din;
        else m0_rdata <= ppi_din;
      end
      m0_ack <= (state_d == ST_ACK) && !txn_id;
      m1_ack <= (state_d == ST_ACK) && txn_id;
      if (state_q == ST_HOLD && phase_end && txn_init) init_done <= 1'b1;
      busy <= (state_d != ST_IDLE);
    end
  end

endmodule
